ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Upstream stage of the target latch. Deserializes PS/2 keyboard frames (scan code set 2) and tracks make/break codes.
- Drives keys_code: a 36-bit one-hot vector, bits 0-25 = A-Z, bits 26-35 = digits 0-9.
- keys_code is nonzero only while a mapped key is held, and returns to 0 on its release.
- The downstream latch keeps the last nonzero value.

Parameters:
- TIMEOUT_CYCLES, 100000: system clocks without a PS/2 falling edge before a partial frame is discarded.
- SYNC_STAGES, 2: flip-flop depth of the ps2_clk/ps2_data synchronizers (minimum 2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock from keyboard, asynchronous
- ps2_data  in  1  raw PS/2 data from keyboard, asynchronous
- keys_code  out  36  one-hot code of currently held mapped key; 0 when none held
- key_valid  out  1  one-cycle pulse when keys_code takes a new nonzero value
- frame_err  out  1  one-cycle pulse on a start, stop or parity error, or on a timeout

Behaviour:
- Reset (rst_n low, asynchronous): keys_code=0, key_valid=0, frame_err=0, all FSMs to idle, bit counter=0, timeout counter=0.
  - Synchronizer flops reset to 1 (PS/2 idle-high).
  - Reset mid-frame discards the partial frame.
- Sampling:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is synchronized clk going 1->0. On that cycle, synchronized data is shifted in LSB-first.
- Frame: 11 bits = start(0), 8 data bits, odd parity, stop(1).
  - Bit counter 0..10. Completion is at the 11th falling edge.
  - Valid frame: start=0, stop=1, XOR of data bits and parity = 1. A valid frame produces the byte on the following cycle.
  - Invalid frame: frame_err pulses, the byte is dropped, the counter returns to 0.
- Timeout: the counter resets on every falling edge and counts while bit counter != 0.
  - Reaching TIMEOUT_CYCLES-1: bit counter to 0, frame_err pulses once.
- Byte FSM states:
  - IDLE
    - byte F0 -> BREAK
    - byte E0 -> EXT
    - mapped make code -> apply make, stay IDLE
    - unmapped byte -> ignored
  - BREAK: next byte is a release.
    - If its index matches the bit set in keys_code, keys_code <= 0.
    - Always return to IDLE.
  - EXT: next byte F0 -> EXT_BREAK; any other byte is consumed and ignored -> IDLE. Extended keys are never mapped.
  - EXT_BREAK: consume the next byte, ignore it -> IDLE.
- Apply make:
  - keys_code <= one-hot(index); this replaces any previously held key (last key wins).
  - key_valid pulses in the same cycle keys_code updates, only if the new value differs from the old one.
  - Typematic repeats of the held key produce no pulse.
- Release of a non-current key (after last-key-wins): no change to keys_code.
- Latency: keys_code and key_valid update 2 clk cycles after the sync-domain falling edge of the 11th bit.
- Scan-code map:
  - Letters: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A
  - Digits: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46
- Outputs are registered. key_valid and frame_err are never asserted in consecutive cycles by a single event.

Test Plan:
- Make 1C -> keys_code=36'h000000001, key_valid one pulse. Then F0 1C -> keys_code=0, no key_valid pulse.
- Make 46 (digit 9) three times (typematic) -> keys_code=36'h800000000 (bit 35), exactly one key_valid pulse.
- Make 1C, then make 32 -> keys_code=bit1 with a second key_valid. Then F0 1C -> keys_code stays bit1. Then F0 32 -> 0.
- Frame for 0x1C with even parity -> frame_err pulse, keys_code unchanged (0), no key_valid. Frame with stop=0 -> same.
- E0 75 then E0 F0 75 (extended up-arrow), and unmapped 0x5A -> keys_code stays 0, no pulses. Next 0x24 -> keys_code=bit4.
- 5 bits of a frame, then idle for TIMEOUT_CYCLES -> one frame_err pulse; a following full 0x15 frame decodes to bit16. Assert rst_n low mid-frame -> all outputs 0 immediately, next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the PS/2 line inputs and the decoded key outputs.
// The keyboard side (or a bench) uses master; the decoder uses slave.
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [35:0] keys_code;
  logic        key_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keys_code, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keys_code, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder (scan code set 2). Deserializes 11-bit frames,
// tracks make/break/extended prefixes and presents the currently held
// letter/digit key as a 36-bit one-hot code (A-Z = bits 0-25, 0-9 = 26-35).
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input logic              clk,
  input logic              rst_n,
  ps2_key_decoder_if.slave bus
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  // Returns {hit, index}; index is the one-hot bit position of the key.
  function automatic logic [6:0] scan_lookup(input logic [7:0] code);
    logic [6:0] r;
    r = '0;
    case (code)
      8'h1C: r = {1'b1, 6'd0};   8'h32: r = {1'b1, 6'd1};
      8'h21: r = {1'b1, 6'd2};   8'h23: r = {1'b1, 6'd3};
      8'h24: r = {1'b1, 6'd4};   8'h2B: r = {1'b1, 6'd5};
      8'h34: r = {1'b1, 6'd6};   8'h33: r = {1'b1, 6'd7};
      8'h43: r = {1'b1, 6'd8};   8'h3B: r = {1'b1, 6'd9};
      8'h42: r = {1'b1, 6'd10};  8'h4B: r = {1'b1, 6'd11};
      8'h3A: r = {1'b1, 6'd12};  8'h31: r = {1'b1, 6'd13};
      8'h44: r = {1'b1, 6'd14};  8'h4D: r = {1'b1, 6'd15};
      8'h15: r = {1'b1, 6'd16};  8'h2D: r = {1'b1, 6'd17};
      8'h1B: r = {1'b1, 6'd18};  8'h2C: r = {1'b1, 6'd19};
      8'h3C: r = {1'b1, 6'd20};  8'h2A: r = {1'b1, 6'd21};
      8'h1D: r = {1'b1, 6'd22};  8'h22: r = {1'b1, 6'd23};
      8'h35: r = {1'b1, 6'd24};  8'h1A: r = {1'b1, 6'd25};
      8'h45: r = {1'b1, 6'd26};  8'h16: r = {1'b1, 6'd27};
      8'h1E: r = {1'b1, 6'd28};  8'h26: r = {1'b1, 6'd29};
      8'h25: r = {1'b1, 6'd30};  8'h2E: r = {1'b1, 6'd31};
      8'h36: r = {1'b1, 6'd32};  8'h3D: r = {1'b1, 6'd33};
      8'h3E: r = {1'b1, 6'd34};  8'h46: r = {1'b1, 6'd35};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [10:0]            shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_vld_q, byte_vld_d;
  logic                   frame_err_q, frame_err_d;
  state_t                 state_q, state_d;
  logic [35:0]            keys_q, keys_d;
  logic                   key_valid_q, key_valid_d;

  logic        ps2_clk_s, ps2_data_s, fall;
  logic [6:0]  lookup;
  logic        hit;
  logic [35:0] onehot;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  // Synchronizer shift chains; the raw line enters at bit 0.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
    clk_prev_d  = ps2_clk_s;
  end

  // Frame deserializer: shift on falling edges, validate on the 11th bit,
  // discard a partial frame when the line goes quiet too long.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    if (fall) begin
      tmo_d   = '0;
      shift_d = {ps2_data_s, shift_q[10:1]};
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_d[0]=start, [8:1]=data, [9]=parity, [10]=stop
        if (!shift_d[0] && shift_d[10] && (^shift_d[9:1])) begin
          byte_d     = shift_d[8:1];
          byte_vld_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TMO_LAST) begin
        bit_cnt_d   = 4'd0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign lookup = scan_lookup(byte_q);
  assign hit    = lookup[6];
  assign onehot = 36'd1 << lookup[5:0];

  // Byte FSM: prefix tracking and make/break application to the held key.
  always_comb begin
    state_d     = state_q;
    keys_d      = keys_q;
    key_valid_d = 1'b0;
    if (byte_vld_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_q == 8'hF0) begin
            state_d = S_BREAK;
          end else if (byte_q == 8'hE0) begin
            state_d = S_EXT;
          end else if (hit) begin
            keys_d      = onehot;
            key_valid_d = (onehot != keys_q);
          end
        end
        S_BREAK: begin
          // Only releasing the key currently shown clears the output.
          if (hit && ((keys_q & onehot) != 36'd0)) keys_d = '0;
          state_d = S_IDLE;
        end
        S_EXT:       state_d = (byte_q == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        S_EXT_BREAK: state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // State registers; synchronizers idle high so reset produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= S_IDLE;
      keys_q      <= '0;
      key_valid_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      keys_q      <= keys_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign bus.keys_code = keys_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed test-plan steps followed by random
// key sequences, checked against a prefix-rule model of the keyboard protocol.
module tb_ps2_key_decoder;
  localparam int TMO  = 200;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.key_valid === 1'b1) kv_cnt++;
      if (bus.frame_err === 1'b1) fe_cnt++;
    end
  end

  // Key table: A..Z then 0..9; position in the table is the one-hot bit.
  logic [7:0] codes [0:35] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] unmapped [0:5] = '{8'h5A, 8'h29, 8'h66, 8'h0D, 8'h76, 8'h12};

  // Reference model: which key is held and what the last prefix bytes were.
  int m_held = -1;
  bit m_brk = 0, m_ext = 0, m_extbrk = 0;
  int exp_kv = 0, exp_fe = 0;

  function automatic int key_index(input logic [7:0] b);
    for (int i = 0; i < 36; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [35:0] exp_keys();
    if (m_held < 0) return 36'd0;
    return 36'd1 << m_held;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    k = key_index(b);
    if (m_extbrk) m_extbrk = 0;
    else if (m_ext) begin
      m_ext = 0;
      if (b == 8'hF0) m_extbrk = 1;
    end else if (m_brk) begin
      m_brk = 0;
      if (k >= 0 && k == m_held) m_held = -1;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (k >= 0) begin
      if (k != m_held) exp_kv++;
      m_held = k;
    end
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_keys"}, bus.keys_code, exp_keys());
    check({tag, "_kv"}, 36'(kv_cnt), 36'(exp_kv));
    check({tag, "_fe"}, 36'(fe_cnt), 36'(exp_fe));
  endtask

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = frame[i];
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic       par;
    logic [10:0] frame;
    par   = (~^b) ^ bad_par;
    frame = {~bad_stop, par, b, 1'b0};
    send_bits(frame, 11);
    repeat (8) @(posedge clk);
    @(negedge clk);
    if (!bad_par && !bad_stop) model_byte(b);
    else exp_fe++;
    $display("[TB] byte %02h bad_par=%0b bad_stop=%0b keys=%09h kv=%0d fe=%0d",
             b, bad_par, bad_stop, bus.keys_code, kv_cnt, fe_cnt);
    check_all($sformatf("byte_%02h", b));
  endtask

  initial begin
    int op, k;
    logic [10:0] part;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_keys", bus.keys_code, 36'd0);
    check("reset_kv", {35'd0, bus.key_valid}, 36'd0);
    check("reset_fe", {35'd0, bus.frame_err}, 36'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Make A, release A
    send_byte(8'h1C, 0, 0);
    check("tp_make_a", bus.keys_code, 36'h000000001);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    // Typematic digit 9
    repeat (3) send_byte(8'h46, 0, 0);
    check("tp_typematic", bus.keys_code, 36'h800000000);
    send_byte(8'hF0, 0, 0); send_byte(8'h46, 0, 0);
    // Last key wins, stale release ignored
    send_byte(8'h1C, 0, 0);
    send_byte(8'h32, 0, 0);
    send_byte(8'hF0, 0, 0); send_byte(8'h1C, 0, 0);
    check("tp_stale_release", bus.keys_code, 36'h000000002);
    send_byte(8'hF0, 0, 0); send_byte(8'h32, 0, 0);
    // Bad parity, bad stop
    send_byte(8'h1C, 1, 0);
    send_byte(8'h1C, 0, 1);
    // Extended and unmapped
    send_byte(8'hE0, 0, 0); send_byte(8'h75, 0, 0);
    send_byte(8'hE0, 0, 0); send_byte(8'hF0, 0, 0); send_byte(8'h75, 0, 0);
    send_byte(8'h5A, 0, 0);
    send_byte(8'h24, 0, 0);
    check("tp_after_ext", bus.keys_code, 36'h000000010);

    // Timeout on a 5-bit partial frame
    part = {1'b1, ~^8'h33, 8'h33, 1'b0};
    send_bits(part, 5);
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    exp_fe++;
    $display("[TB] timeout fe=%0d", fe_cnt);
    check_all("timeout");
    send_byte(8'h15, 0, 0);
    check("tp_after_tmo", bus.keys_code, 36'h000010000);

    // Asynchronous reset mid-frame
    send_bits(part, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-frame keys=%09h", bus.keys_code);
    check("rst_keys", bus.keys_code, 36'd0);
    check("rst_kv", {35'd0, bus.key_valid}, 36'd0);
    check("rst_fe", {35'd0, bus.frame_err}, 36'd0);
    m_held = -1; m_brk = 0; m_ext = 0; m_extbrk = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send_byte(8'h1C, 0, 0);
    check("tp_after_rst", bus.keys_code, 36'h000000001);

    // Random sequences
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 6);
      k  = $urandom_range(0, 35);
      case (op)
        0, 1: send_byte(codes[k], 0, 0);
        2: send_byte((m_held >= 0) ? codes[m_held] : codes[k], 0, 0);
        3: begin
          send_byte(8'hF0, 0, 0);
          send_byte((m_held >= 0) ? codes[m_held] : codes[k], 0, 0);
        end
        4: begin send_byte(8'hF0, 0, 0); send_byte(codes[k], 0, 0); end
        5: begin
          send_byte(8'hE0, 0, 0);
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 0, 0);
          send_byte(($urandom_range(0, 1) == 1) ? 8'h75 : codes[k], 0, 0);
        end
        default: begin
          if ($urandom_range(0, 1) == 1)
            send_byte(unmapped[$urandom_range(0, 5)], 0, 0);
          else if ($urandom_range(0, 1) == 1)
            send_byte(codes[k], 1, 0);
          else
            send_byte(codes[k], 0, 1);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
